cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 register file and exception resolver for the 5-stage sram-like MIPS core.
- Consumes the per-instruction control flags the decode stage produces (syscall, break, invalid, eret, cp0we, cp0read), after they are piped to the M stage together with datapath faults.
- Arbitrates exceptions, updates Status/Cause/EPC/BadVAddr/Count/Compare, and drives pipeline flush plus the redirect PC.
- Serves MFC0 reads and MTC0 writes.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0).

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- we_i  in  1  MTC0 write strobe (cp0we, M stage)
- waddr_i  in  5  MTC0 rd field
- wdata_i  in  32  MTC0 data (rt value)
- raddr_i  in  5  MFC0 rd field
- rdata_o  out  32  MFC0 read data
- int_i  in  6  external hardware interrupts, level-sensitive
- syscall_i, break_i, ri_i, eret_i  in  1 each  decode flags for the M-stage instruction
- ov_i  in  1  arithmetic overflow
- adel_if_i, adel_mem_i, ades_i  in  1 each  fetch/load/store address errors
- badaddr_i  in  32  faulting data address
- pc_i  in  32  M-stage instruction PC
- in_ds_i  in  1  M-stage instruction is in a delay slot
- valid_i  in  1  M stage holds a real instruction (not a bubble)
- flush_o  out  1  flush all stages
- newpc_o  out  32  redirect target while flush_o=1
- status_o, cause_o, epc_o  out  32 each  architectural copies

Behaviour:
- Registers are Status(12), Cause(13), EPC(14), BadVAddr(8), Count(9), Compare(11); every other address reads 0.
- Reset: Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare=0; internal tick=0; flush_o=0.
- Exception detect is combinational on M-stage inputs, gated by valid_i.
  - Priority: Int > AdEL(fetch) > RI > Ov > Sys > Bp > AdEL(data) > AdES > ERET.
  - Int = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - ExcCodes: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
- flush_o=1 in the same cycle as any exception or ERET.
  - newpc_o = EPC for ERET.
  - newpc_o = EXC_VECTOR for everything else.
  - newpc_o = 0 when flush_o=0.
- Exception commit, on the next clk edge:
  - Status.EXL<=1.
  - Cause.ExcCode<=code.
  - Cause.BD<=in_ds_i.
  - EPC <= in_ds_i ? pc_i-4 : pc_i.
  - BadVAddr <= pc_i for fetch AdEL, badaddr_i for data AdEL/AdES; BadVAddr is unchanged otherwise.
- If Status.EXL=1 already: EPC and BD are not updated; ExcCode still updates.
- ERET commit: Status.EXL<=0.
- MTC0:
  - Applied on the edge when we_i=1 and there is no exception that cycle.
  - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8] (software IRQs); EPC all bits; Count all bits; Compare all bits.
  - Writing Compare clears Cause.TI.
  - Writes to BadVAddr are ignored.
- Cause.IP[7:2] samples int_i every cycle. When the timer is enabled, IP[7] = int_i[5] | Cause.TI.
- rdata_o is combinational from the current register values. There is no same-cycle write bypass; the forwarding unit handles hazards.
- Exception and MTC0 in the same cycle: the exception wins and the write is dropped.
- Exception and Count rollover in the same cycle: both take effect.
- resetn asserted mid-exception: all state returns to reset values immediately; flush_o drops asynchronously.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined:
  - The 1-bit tick toggles every cycle.
  - Count increments by 1 (wrapping 32'hFFFF_FFFF->0) on cycles where tick=1, i.e. half the clock rate.
  - When Count==Compare and Compare!=0, Cause.TI<=1 on the next edge and stays set until Compare is written.
  - An MTC0 to Count takes priority over the increment in the same cycle.
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - Cause.TI=0.
  - IP[7]=int_i[5].

Decomposition:
- Shared package/header cp0_defs holds:
  - register addresses
  - ExcCode constants
  - Status/Cause bit-position constants
  - EXC_VECTOR default
- One natural sub-module, cp0_exc_arb: a purely combinational priority encoder producing exc_valid, exc_code, and the BadVAddr source select.

Test Plan:
- Reset release -> status_o=32'h0040_0000, cause_o=0, epc_o=0, flush_o=0; MFC0 of reg 12 returns 32'h0040_0000.
- syscall_i=1, pc_i=32'hBFC0_0100, in_ds_i=0 -> flush_o=1 and newpc_o=32'hBFC0_0380 that cycle; next cycle EPC=32'hBFC0_0100, ExcCode=8, EXL=1.
- ov_i=1 together with break_i=1, in_ds_i=1, pc_i=32'hBFC0_0204 -> ExcCode=12 (Ov), EPC=32'hBFC0_0200, Cause.BD=1.
- ERET with EPC=32'hBFC0_0104 -> flush_o=1, newpc_o=32'hBFC0_0104, EXL cleared next cycle.
- MTC0 Status=32'h0000_0401 then int_i[0]=1 -> interrupt flush, ExcCode=0; same cycle MTC0 EPC=32'h1234 is dropped.
- [CP0_TIMER_EN] MTC0 Compare=10, Count=0 -> TI set after about 20 cycles; an interrupt is taken once IM7=1, IE=1 (the IE write is applied the cycle after the Compare write); rewriting Compare clears TI.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit
// positions and reset/vector defaults used by the CP0 exception unit.
package cp0_defs;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;

    // Only IM[15:8], EXL and IE of Status are software-writable
    localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    typedef enum logic [1:0] {
        BAD_NONE = 2'd0,
        BAD_PC   = 2'd1,
        BAD_ADDR = 2'd2
    } bad_sel_e;

endpackage

// File: rtl/cp0_exc_unit_arb.sv
// Combinational exception priority encoder for the M-stage instruction.
module cp0_exc_arb
    import cp0_defs::*;
(
    input  logic       valid_i,
    input  logic       int_i,
    input  logic       adel_if_i,
    input  logic       ri_i,
    input  logic       ov_i,
    input  logic       sys_i,
    input  logic       bp_i,
    input  logic       adel_mem_i,
    input  logic       ades_i,
    output logic       exc_valid_o,
    output logic [4:0] exc_code_o,
    output bad_sel_e   bad_sel_o
);

    always_comb begin
        exc_valid_o = 1'b0;
        exc_code_o  = EXC_INT;
        bad_sel_o   = BAD_NONE;
        if (valid_i) begin
            exc_valid_o = 1'b1;
            if (int_i) begin
                exc_code_o = EXC_INT;
            end else if (adel_if_i) begin
                exc_code_o = EXC_ADEL;
                bad_sel_o  = BAD_PC;
            end else if (ri_i) begin
                exc_code_o = EXC_RI;
            end else if (ov_i) begin
                exc_code_o = EXC_OV;
            end else if (sys_i) begin
                exc_code_o = EXC_SYS;
            end else if (bp_i) begin
                exc_code_o = EXC_BP;
            end else if (adel_mem_i) begin
                exc_code_o = EXC_ADEL;
                bad_sel_o  = BAD_ADDR;
            end else if (ades_i) begin
                exc_code_o = EXC_ADES;
                bad_sel_o  = BAD_ADDR;
            end else begin
                exc_valid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file and exception resolver for the M stage.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_exc_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        ri_i,
    input  logic        eret_i,
    input  logic        ov_i,
    input  logic        adel_if_i,
    input  logic        adel_mem_i,
    input  logic        ades_i,
    input  logic [31:0] badaddr_i,
    input  logic [31:0] pc_i,
    input  logic        in_ds_i,
    input  logic        valid_i,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q, bd_d;
    logic        ti_q;
    logic [31:0] count_q, compare_q;
    logic        timer_irq;

    logic        int_pending;
    logic        exc_valid;
    logic [4:0]  exc_code;
    bad_sel_e    bad_sel;
    logic        eret_fire;
    logic        wr_en;

    assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL]
                       & (|(ip_q & status_q[ST_IM_LO +: 8]));

    cp0_exc_arb u_arb (
        .valid_i     (valid_i),
        .int_i       (int_pending),
        .adel_if_i   (adel_if_i),
        .ri_i        (ri_i),
        .ov_i        (ov_i),
        .sys_i       (syscall_i),
        .bp_i        (break_i),
        .adel_mem_i  (adel_mem_i),
        .ades_i      (ades_i),
        .exc_valid_o (exc_valid),
        .exc_code_o  (exc_code),
        .bad_sel_o   (bad_sel)
    );

    assign eret_fire = valid_i & eret_i & ~exc_valid;
    // An exception swallows any MTC0 issued in the same cycle
    assign wr_en     = we_i & ~exc_valid;
    assign flush_o   = resetn & (exc_valid | eret_fire);
    assign newpc_o   = !flush_o ? 32'd0 : (exc_valid ? EXC_VECTOR : epc_q);

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        exccode_d  = exccode_q;
        bd_d       = bd_q;
        ip_d       = {int_i[5] | timer_irq, int_i[4:0], ip_q[1:0]};

        if (wr_en && waddr_i == REG_STATUS)
            status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        if (wr_en && waddr_i == REG_CAUSE)
            ip_d[1:0] = wdata_i[9:8];
        if (wr_en && waddr_i == REG_EPC)
            epc_d = wdata_i;

        if (exc_valid) begin
            status_d[ST_EXL] = 1'b1;
            exccode_d        = exc_code;
            // A nested exception keeps the original return point
            if (!status_q[ST_EXL]) begin
                bd_d  = in_ds_i;
                epc_d = in_ds_i ? (pc_i - 32'd4) : pc_i;
            end
            if (bad_sel == BAD_PC)
                badvaddr_d = pc_i;
            else if (bad_sel == BAD_ADDR)
                badvaddr_d = badaddr_i;
        end else if (eret_fire) begin
            status_d[ST_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ip_q       <= '0;
            exccode_q  <= '0;
            bd_q       <= 1'b0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ip_q       <= ip_d;
            exccode_q  <= exccode_d;
            bd_q       <= bd_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick_q, tick_d;
    logic [31:0] count_d, compare_d;
    logic        ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'd0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_q == compare_q && compare_q != 32'd0)
            ti_d = 1'b1;
        if (wr_en && waddr_i == REG_COUNT)
            count_d = wdata_i;
        if (wr_en && waddr_i == REG_COMPARE) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign timer_irq = ti_d;
`else
    assign count_q   = '0;
    assign compare_q = '0;
    assign ti_q      = 1'b0;
    assign timer_irq = 1'b0;
`endif

    assign status_o = status_q;
    assign cause_o  = {bd_q, ti_q, 14'd0, ip_q, 1'b0, exccode_q, 2'b00};
    assign epc_o    = epc_q;

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            REG_STATUS:   rdata_o = status_q;
            REG_CAUSE:    rdata_o = cause_o;
            REG_EPC:      rdata_o = epc_q;
            REG_BADVADDR: rdata_o = badvaddr_q;
            REG_COUNT:    rdata_o = count_q;
            REG_COMPARE:  rdata_o = compare_q;
            default:      rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed, table-driven bench for cp0_exc_unit plus reset and timer sequences.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        syscall_i, break_i, ri_i, eret_i, ov_i;
    logic        adel_if_i, adel_mem_i, ades_i;
    logic [31:0] badaddr_i, pc_i;
    logic        in_ds_i, valid_i;
    logic        flush_o;
    logic [31:0] newpc_o, status_o, cause_o, epc_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .int_i      (int_i),
        .syscall_i  (syscall_i),
        .break_i    (break_i),
        .ri_i       (ri_i),
        .eret_i     (eret_i),
        .ov_i       (ov_i),
        .adel_if_i  (adel_if_i),
        .adel_mem_i (adel_mem_i),
        .ades_i     (ades_i),
        .badaddr_i  (badaddr_i),
        .pc_i       (pc_i),
        .in_ds_i    (in_ds_i),
        .valid_i    (valid_i),
        .flush_o    (flush_o),
        .newpc_o    (newpc_o),
        .status_o   (status_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o)
    );

    localparam logic [8:0] F_V     = 9'h001;
    localparam logic [8:0] F_ADES  = 9'h002;
    localparam logic [8:0] F_ADELM = 9'h004;
    localparam logic [8:0] F_ADELI = 9'h008;
    localparam logic [8:0] F_OV    = 9'h010;
    localparam logic [8:0] F_ERET  = 9'h020;
    localparam logic [8:0] F_RI    = 9'h040;
    localparam logic [8:0] F_BRK   = 9'h080;
    localparam logic [8:0] F_SYS   = 9'h100;
    localparam logic [31:0] BV     = 32'hBFC0_0380;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  intr;
        logic [8:0]  flags;
        logic [31:0] badaddr;
        logic [31:0] pc;
        logic        ds;
        logic        e_flush;
        logic [31:0] e_newpc;
        logic [31:0] e_rdata;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0;
        int_i = 6'd0; syscall_i = 1'b0; break_i = 1'b0; ri_i = 1'b0;
        eret_i = 1'b0; ov_i = 1'b0; adel_if_i = 1'b0; adel_mem_i = 1'b0;
        ades_i = 1'b0; badaddr_i = 32'd0; pc_i = 32'd0; in_ds_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        clear_inputs();
        valid_i = 1'b1; we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got_flush;
        vec[0]  = '{1'b0, 5'd0,  32'h0,         5'd12, 6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h0};
        vec[1]  = '{1'b0, 5'd0,  32'h0,         5'd13, 6'h00, F_V | F_SYS,       32'h0,         32'hBFC0_0100, 1'b0, 1'b1, BV,            32'h0,         32'h0040_0002, 32'h0000_0020, 32'hBFC0_0100};
        vec[2]  = '{1'b1, 5'd14, 32'hBFC0_0104, 5'd14, 6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'hBFC0_0100, 32'h0040_0002, 32'h0000_0020, 32'hBFC0_0104};
        vec[3]  = '{1'b0, 5'd0,  32'h0,         5'd12, 6'h00, F_V | F_ERET,      32'h0,         32'h0,         1'b0, 1'b1, 32'hBFC0_0104, 32'h0040_0002, 32'h0040_0000, 32'h0000_0020, 32'hBFC0_0104};
        vec[4]  = '{1'b0, 5'd0,  32'h0,         5'd14, 6'h00, F_V | F_OV | F_BRK, 32'h0,        32'hBFC0_0204, 1'b1, 1'b1, BV,            32'hBFC0_0104, 32'h0040_0002, 32'h8000_0030, 32'hBFC0_0200};
        vec[5]  = '{1'b0, 5'd0,  32'h0,         5'd13, 6'h00, F_V | F_ADELM,     32'h0000_1235, 32'h8000_0010, 1'b0, 1'b1, BV,            32'h8000_0030, 32'h0040_0002, 32'h8000_0010, 32'hBFC0_0200};
        vec[6]  = '{1'b0, 5'd0,  32'h0,         5'd8,  6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_1235, 32'h0040_0002, 32'h8000_0010, 32'hBFC0_0200};
        vec[7]  = '{1'b1, 5'd8,  32'hFFFF_FFFF, 5'd8,  6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_1235, 32'h0040_0002, 32'h8000_0010, 32'hBFC0_0200};
        vec[8]  = '{1'b0, 5'd0,  32'h0,         5'd8,  6'h00, F_V | F_ERET,      32'h0,         32'h0,         1'b0, 1'b1, 32'hBFC0_0200, 32'h0000_1235, 32'h0040_0000, 32'h8000_0010, 32'hBFC0_0200};
        vec[9]  = '{1'b0, 5'd0,  32'h0,         5'd12, 6'h00, F_V | F_ADELI | F_RI, 32'hDEAD_0000, 32'h0000_0003, 1'b0, 1'b1, BV,       32'h0040_0000, 32'h0040_0002, 32'h0000_0010, 32'h0000_0003};
        vec[10] = '{1'b1, 5'd12, 32'hFFFF_0401, 5'd8,  6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0003, 32'h0040_0401, 32'h0000_0010, 32'h0000_0003};
        vec[11] = '{1'b0, 5'd0,  32'h0,         5'd13, 6'h01, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0010, 32'h0040_0401, 32'h0000_0410, 32'h0000_0003};
        vec[12] = '{1'b1, 5'd14, 32'h0000_1234, 5'd14, 6'h01, F_V,               32'h0,         32'h8000_1000, 1'b0, 1'b1, BV,            32'h0000_0003, 32'h0040_0403, 32'h0000_0400, 32'h8000_1000};
        vec[13] = '{1'b0, 5'd0,  32'h0,         5'd14, 6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h8000_1000, 32'h0040_0403, 32'h0000_0000, 32'h8000_1000};
        vec[14] = '{1'b1, 5'd13, 32'h0000_0100, 5'd15, 6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h0040_0403, 32'h0000_0100, 32'h8000_1000};
        vec[15] = '{1'b0, 5'd0,  32'h0,         5'd13, 6'h00, F_SYS,             32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0100, 32'h0040_0403, 32'h0000_0100, 32'h8000_1000};
        vec[16] = '{1'b0, 5'd0,  32'h0,         5'd13, 6'h00, F_V | F_ADES,      32'h0000_0006, 32'h8000_2008, 1'b1, 1'b1, BV,            32'h0000_0100, 32'h0040_0403, 32'h0000_0114, 32'h8000_1000};
        vec[17] = '{1'b0, 5'd0,  32'h0,         5'd8,  6'h00, F_V,               32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0006, 32'h0040_0403, 32'h0000_0114, 32'h8000_1000};

        clear_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we_i = vec[i].we; waddr_i = vec[i].waddr; wdata_i = vec[i].wdata;
            raddr_i = vec[i].raddr; int_i = vec[i].intr;
            syscall_i  = vec[i].flags[8]; break_i   = vec[i].flags[7];
            ri_i       = vec[i].flags[6]; eret_i    = vec[i].flags[5];
            ov_i       = vec[i].flags[4]; adel_if_i = vec[i].flags[3];
            adel_mem_i = vec[i].flags[2]; ades_i    = vec[i].flags[1];
            valid_i    = vec[i].flags[0];
            badaddr_i = vec[i].badaddr; pc_i = vec[i].pc; in_ds_i = vec[i].ds;
            #1;
            chk($sformatf("v%0d_flush", i), {31'd0, flush_o}, {31'd0, vec[i].e_flush});
            chk($sformatf("v%0d_newpc", i), newpc_o, vec[i].e_newpc);
            chk($sformatf("v%0d_rdata", i), rdata_o, vec[i].e_rdata);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_status", i), status_o, vec[i].e_status);
            chk($sformatf("v%0d_cause", i), cause_o, vec[i].e_cause);
            chk($sformatf("v%0d_epc", i), epc_o, vec[i].e_epc);
            $display("vec %0d: flush=%0b newpc=%h rdata=%h status=%h cause=%h epc=%h",
                     i, vec[i].e_flush, vec[i].e_newpc, vec[i].e_rdata, status_o, cause_o, epc_o);
        end

        // Reset asserted while an exception is being flagged
        @(negedge clk);
        clear_inputs();
        valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'h8000_3000;
        #1;
        chk("midrst_flush_before", {31'd0, flush_o}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("midrst_flush", {31'd0, flush_o}, 32'h0);
        chk("midrst_newpc", newpc_o, 32'h0);
        chk("midrst_status", status_o, 32'h0040_0000);
        chk("midrst_cause", cause_o, 32'h0);
        chk("midrst_epc", epc_o, 32'h0);
        @(negedge clk);
        clear_inputs();
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_status", status_o, 32'h0040_0000);
        $display("midrst: flush=%0b status=%h", flush_o, status_o);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        got_flush = 1'b0;
        for (int c = 0; c < 80 && !got_flush; c++) begin
            @(negedge clk);
            clear_inputs();
            valid_i = 1'b1; pc_i = 32'h8000_4000;
            #1;
            if (flush_o) begin
                got_flush = 1'b1;
                chk("tmr_newpc", newpc_o, BV);
                @(posedge clk);
                #1;
                chk("tmr_code", {27'd0, cause_o[6:2]}, 32'd0);
                chk("tmr_ti", {31'd0, cause_o[30]}, 32'd1);
                chk("tmr_exl", {31'd0, status_o[1]}, 32'd1);
            end
        end
        chk("tmr_flush_seen", {31'd0, got_flush}, 32'd1);
        mtc0(5'd11, 32'hFFFF_0000);
        chk("tmr_ti_clr", {31'd0, cause_o[30]}, 32'd0);
        @(negedge clk);
        clear_inputs();
        raddr_i = 5'd11;
        #1;
        chk("tmr_cmp_rd", rdata_o, 32'hFFFF_0000);
        @(posedge clk);
        #1;
        chk("tmr_ip7_clr", {31'd0, cause_o[15]}, 32'd0);
        $display("timer: flush_seen=%0b cause=%h", got_flush, cause_o);
`else
        got_flush = 1'b0;
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd5);
        @(negedge clk);
        clear_inputs();
        raddr_i = 5'd11;
        #1;
        chk("notmr_cmp_rd", rdata_o, 32'h0);
        raddr_i = 5'd9;
        #1;
        chk("notmr_cnt_rd", rdata_o, 32'h0);
        $display("no timer: compare/count read 0, flush_seen=%0b", got_flush);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
